// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the thermometer LED sequence monitor.
package led_seq_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned MAX_W      = 32;
  localparam int unsigned DEF_LENGTH = 8;
  localparam int unsigned LEVEL_W    = $clog2(DEF_LENGTH + 1);

  function automatic int unsigned level_w(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Successor of a len-bit fill pattern: full wraps to empty, else one more MSB-side one.
  function automatic logic [MAX_W-1:0] therm_next(input logic [MAX_W-1:0] p,
                                                  input int unsigned     len);
    logic [MAX_W-1:0] mask;
    mask = (len >= MAX_W) ? '1 : ((MAX_W'(1) << len) - MAX_W'(1));
    if ((p & mask) == mask) return '0;
    return ((p & mask) >> 1) | (MAX_W'(1) << (len - 1));
  endfunction

endpackage

// File: rtl/led_sequence_monitor_decode.sv
// Combinational decode of an LED pattern: ones count, thermometer shape, full flag.
module therm_decode #(
  parameter int unsigned W  = 8,
  parameter int unsigned LW = 4
) (
  input  logic [W-1:0]  i_pattern,
  output logic [LW-1:0] o_popcount,
  output logic          o_is_thermometer,
  output logic          o_is_full
);

  logic [W-1:0] w_expect;

  always_comb begin
    o_popcount = '0;
    for (int unsigned i = 0; i < W; i++) o_popcount = o_popcount + LW'(i_pattern[i]);
  end

  // A legal fill of k ones occupies exactly the top k bit positions.
  always_comb begin
    w_expect = '0;
    for (int unsigned i = 0; i < W; i++) w_expect[i] = ((i + 32'(o_popcount)) >= W);
  end

  assign o_is_thermometer = (i_pattern == w_expect);
  assign o_is_full        = &i_pattern;

endmodule

// File: rtl/led_sequence_monitor.sv
// Receive-side checker that tracks an LED thermometer fill sequence and flags illegal steps.
module led_sequence_monitor
  import led_seq_pkg::*;
#(
  parameter int unsigned MAX_LENGTH = 8,
  parameter bit          ALLOW_HOLD = 1'b0,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned CYC_W      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             sample_en,
  input  logic [MAX_LENGTH-1:0]            led_in,
  input  logic                             clr_cnt,
  output logic                             locked,
  output logic [level_w(MAX_LENGTH)-1:0]   level,
  output logic                             level_vld,
  output logic                             cycle_done,
  output logic                             seq_err,
  output logic [ERR_W-1:0]                 err_cnt,
  output logic [CYC_W-1:0]                 cycle_cnt
);

  localparam int unsigned LW = level_w(MAX_LENGTH);

  state_e                r_state, w_state_nxt;
  logic [MAX_LENGTH-1:0] r_prev, w_prev_nxt, w_next;
  logic                  r_prev_full, w_prev_full_nxt;
  logic [LW-1:0]         r_level, w_level_nxt, w_popcnt;
  logic                  r_locked, r_level_vld, r_cycle_done, r_seq_err;
  logic                  w_level_vld_nxt, w_cycle_done_nxt, w_seq_err_nxt;
  logic                  w_is_therm, w_is_full, w_succ, w_hold;
  logic [ERR_W-1:0]      r_err_cnt;
  logic [CYC_W-1:0]      r_cycle_cnt;

  therm_decode #(
    .W  (MAX_LENGTH),
    .LW (LW)
  ) u_decode (
    .i_pattern        (led_in),
    .o_popcount       (w_popcnt),
    .o_is_thermometer (w_is_therm),
    .o_is_full        (w_is_full)
  );

  assign w_next = MAX_LENGTH'(therm_next(MAX_W'(r_prev), MAX_LENGTH));
  assign w_succ = w_is_therm && (led_in == w_next);
  assign w_hold = ALLOW_HOLD && (led_in == r_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_prev_full_nxt  = r_prev_full;
    w_level_nxt      = r_level;
    w_level_vld_nxt  = 1'b0;
    w_cycle_done_nxt = 1'b0;
    w_seq_err_nxt    = 1'b0;
    if (sample_en) begin
      case (r_state)
        HUNT: begin
          if (led_in == '0) begin
            w_state_nxt     = LOCKED;
            w_prev_nxt      = '0;
            w_prev_full_nxt = 1'b0;
            w_level_nxt     = '0;
            w_level_vld_nxt = 1'b1;
          end
        end
        LOCKED: begin
          if (w_succ) begin
            w_prev_nxt       = led_in;
            w_prev_full_nxt  = w_is_full;
            w_level_nxt      = w_popcnt;
            w_level_vld_nxt  = 1'b1;
            w_cycle_done_nxt = r_prev_full;
          end else if (!w_hold) begin
            // A bad zero does not relock here; only the next zero sample does.
            w_seq_err_nxt = 1'b1;
            w_state_nxt   = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= '0;
      r_prev_full  <= 1'b0;
      r_level      <= '0;
      r_locked     <= 1'b0;
      r_level_vld  <= 1'b0;
      r_cycle_done <= 1'b0;
      r_seq_err    <= 1'b0;
      r_err_cnt    <= '0;
      r_cycle_cnt  <= '0;
    end else begin
      r_prev       <= w_prev_nxt;
      r_prev_full  <= w_prev_full_nxt;
      r_level      <= w_level_nxt;
      r_locked     <= (w_state_nxt == LOCKED);
      r_level_vld  <= w_level_vld_nxt;
      r_cycle_done <= w_cycle_done_nxt;
      r_seq_err    <= w_seq_err_nxt;
      // Clear has priority over any coincident increment.
      if (clr_cnt) begin
        r_err_cnt   <= '0;
        r_cycle_cnt <= '0;
      end else begin
        if (w_seq_err_nxt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERR_W'(1);
        if (w_cycle_done_nxt)                   r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
      end
    end
  end

  assign locked     = r_locked;
  assign level      = r_level;
  assign level_vld  = r_level_vld;
  assign cycle_done = r_cycle_done;
  assign seq_err    = r_seq_err;
  assign err_cnt    = r_err_cnt;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_led_sequence_monitor.sv
// Bench for led_sequence_monitor: directed scenarios plus random traffic against a level-based model.
module tb_led_sequence_monitor;
  import led_seq_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned LW = LEVEL_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_en = 1'b0;
  logic         clr_cnt = 1'b0;
  logic [N-1:0] led_in = '0;

  logic          d_locked [2];
  logic          d_vld    [2];
  logic          d_done   [2];
  logic          d_err    [2];
  logic [LW-1:0] d_level  [2];
  logic [7:0]    d_errc   [2];
  logic [15:0]   d_cyc    [2];

  int tests_run = 0;
  int tests_failed = 0;

  // Model state per instance (index 0: no hold allowed, 1: hold allowed); prev tracked as fill level
  int m_locked [2];
  int m_k      [2];
  int m_level  [2];
  int m_vld    [2];
  int m_done   [2];
  int m_err    [2];
  int m_errc   [2];
  int m_cyc    [2];

  always #5 clk = ~clk;

  led_sequence_monitor #(.MAX_LENGTH(N), .ALLOW_HOLD(1'b0), .ERR_W(8), .CYC_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .led_in(led_in), .clr_cnt(clr_cnt),
    .locked(d_locked[0]), .level(d_level[0]), .level_vld(d_vld[0]), .cycle_done(d_done[0]),
    .seq_err(d_err[0]), .err_cnt(d_errc[0]), .cycle_cnt(d_cyc[0])
  );

  led_sequence_monitor #(.MAX_LENGTH(N), .ALLOW_HOLD(1'b1), .ERR_W(8), .CYC_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .led_in(led_in), .clr_cnt(clr_cnt),
    .locked(d_locked[1]), .level(d_level[1]), .level_vld(d_vld[1]), .cycle_done(d_done[1]),
    .seq_err(d_err[1]), .err_cnt(d_errc[1]), .cycle_cnt(d_cyc[1])
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int therm(input int n);
    int v;
    v = 32'hFF << (8 - n);
    return v & 32'hFF;
  endfunction

  task automatic m_reset();
    for (int h = 0; h < 2; h++) begin
      m_locked[h] = 0; m_k[h] = 0; m_level[h] = 0; m_vld[h] = 0;
      m_done[h] = 0; m_err[h] = 0; m_errc[h] = 0; m_cyc[h] = 0;
    end
  endtask

  task automatic m_step(input int h, input bit en, input int led, input bit clr);
    int nx;
    m_vld[h] = 0; m_done[h] = 0; m_err[h] = 0;
    if (en) begin
      if (m_locked[h] == 0) begin
        if (led == 0) begin
          m_locked[h] = 1; m_k[h] = 0; m_level[h] = 0; m_vld[h] = 1;
        end
      end else begin
        nx = (m_k[h] == 8) ? 0 : m_k[h] + 1;
        if (led == therm(nx)) begin
          if (m_k[h] == 8) m_done[h] = 1;
          m_k[h] = nx; m_level[h] = nx; m_vld[h] = 1;
        end else if (!(h == 1 && led == therm(m_k[h]))) begin
          m_err[h] = 1; m_locked[h] = 0;
        end
      end
    end
    if (clr) begin
      m_errc[h] = 0; m_cyc[h] = 0;
    end else begin
      if (m_err[h] == 1 && m_errc[h] < 255) m_errc[h]++;
      if (m_done[h] == 1) m_cyc[h] = (m_cyc[h] + 1) % 65536;
    end
  endtask

  task automatic step(input bit en, input logic [7:0] led, input bit clr);
    @(negedge clk);
    sample_en = en; led_in = led; clr_cnt = clr;
    @(posedge clk);
    for (int h = 0; h < 2; h++) m_step(h, en, int'(led), clr);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_en = 1'b0; led_in = '0; clr_cnt = 1'b0;
    rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    do_reset();
    step(1, 8'h00, 0); step(1, 8'h80, 0); step(1, 8'hC0, 0);
    repeat (3 + $urandom_range(0, 8)) step(1'($urandom), 8'($urandom), 0);
    @(negedge clk);
    #($urandom_range(1, 4));
    rst_n = 1'b0;
    m_reset();
    #1;
    for (int h = 0; h < 2; h++) begin
      got = {d_locked[h], d_level[h], d_vld[h], d_done[h], d_err[h], d_errc[h], d_cyc[h]};
      tests_run++;
      if (got !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_zero[%0d]: got %h want 00000000", h, got);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 0);
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_locked[h] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_release_locked[%0d]: got %b want 0", h, d_locked[h]);
      end
    end
  endtask

  task automatic test_full_cycle();
    logic [7:0] seq [10] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00};
    int         lv  [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, seq[i], 0);
      for (int h = 0; h < 2; h++) begin
        tests_run++;
        if (d_level[h] !== LW'(lv[i]) || d_locked[h] !== 1'b1 || d_vld[h] !== 1'b1 ||
            d_done[h] !== (i == 9) || d_err[h] !== 1'b0) begin
          tests_failed++;
          $display("FAIL full_cycle[%0d][%0d]: level=%0d locked=%b vld=%b done=%b err=%b want level=%0d locked=1 vld=1 done=%b err=0",
                   h, i, d_level[h], d_locked[h], d_vld[h], d_done[h], d_err[h], lv[i], (i == 9));
        end
      end
    end
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_cyc[h] !== 16'd1 || d_errc[h] !== 8'd0) begin
        tests_failed++;
        $display("FAIL full_cycle_counts[%0d]: cycle_cnt=%0d err_cnt=%0d want 1 and 0", h, d_cyc[h], d_errc[h]);
      end
    end
  endtask

  task automatic test_corruption();
    do_reset();
    step(1, 8'h00, 0); step(1, 8'h80, 0); step(1, 8'hA0, 0);
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_err[h] !== 1'b1 || d_errc[h] !== 8'd1 || d_locked[h] !== 1'b0 || d_level[h] !== LW'(1)) begin
        tests_failed++;
        $display("FAIL corruption[%0d]: err=%b cnt=%0d locked=%b level=%0d want 1 1 0 1",
                 h, d_err[h], d_errc[h], d_locked[h], d_level[h]);
      end
    end
    step(1, 8'hC0, 0);
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_locked[h] !== 1'b0 || d_err[h] !== 1'b0 || d_vld[h] !== 1'b0) begin
        tests_failed++;
        $display("FAIL corruption_hunt[%0d]: locked=%b err=%b vld=%b want 0 0 0", h, d_locked[h], d_err[h], d_vld[h]);
      end
    end
    step(1, 8'h00, 0);
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_locked[h] !== 1'b1 || d_vld[h] !== 1'b1 || d_level[h] !== LW'(0)) begin
        tests_failed++;
        $display("FAIL corruption_relock[%0d]: locked=%b vld=%b level=%0d want 1 1 0", h, d_locked[h], d_vld[h], d_level[h]);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(1, 8'h00, 0); step(1, 8'h80, 0); step(1, 8'h80, 0);
    tests_run++;
    if (d_err[0] !== 1'b1 || d_locked[0] !== 1'b0 || d_errc[0] !== 8'd1) begin
      tests_failed++;
      $display("FAIL hold_disallowed: err=%b locked=%b cnt=%0d want 1 0 1", d_err[0], d_locked[0], d_errc[0]);
    end
    tests_run++;
    if (d_err[1] !== 1'b0 || d_locked[1] !== 1'b1 || d_level[1] !== LW'(1) || d_vld[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_allowed: err=%b locked=%b level=%0d vld=%b want 0 1 1 0",
               d_err[1], d_locked[1], d_level[1], d_vld[1]);
    end
    step(1, 8'hC0, 0);
    tests_run++;
    if (d_level[1] !== LW'(2) || d_vld[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_resume: level=%0d vld=%b want 2 1", d_level[1], d_vld[1]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (300) begin
      step(1, 8'h00, 0);
      step(1, 8'h55, 0);
    end
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_errc[h] !== 8'd255) begin
        tests_failed++;
        $display("FAIL saturation[%0d]: err_cnt=%0d want 255", h, d_errc[h]);
      end
    end
    step(1, 8'h00, 0);
    step(1, 8'h55, 1);
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_err[h] !== 1'b1 || d_errc[h] !== 8'd0 || d_cyc[h] !== 16'd0) begin
        tests_failed++;
        $display("FAIL clear_wins[%0d]: err=%b err_cnt=%0d cycle_cnt=%0d want 1 0 0", h, d_err[h], d_errc[h], d_cyc[h]);
      end
    end
  endtask

  task automatic test_gating();
    do_reset();
    step(1, 8'h00, 0); step(1, 8'h80, 0); step(1, 8'hC0, 0); step(1, 8'hE0, 0);
    repeat (20) begin
      step(0, 8'($urandom), 0);
      for (int h = 0; h < 2; h++) begin
        tests_run++;
        if (d_vld[h] !== 1'b0 || d_err[h] !== 1'b0 || d_done[h] !== 1'b0 ||
            d_locked[h] !== 1'b1 || d_level[h] !== LW'(3) || d_errc[h] !== 8'd0) begin
          tests_failed++;
          $display("FAIL gating[%0d]: vld=%b err=%b done=%b locked=%b level=%0d cnt=%0d want 0 0 0 1 3 0",
                   h, d_vld[h], d_err[h], d_done[h], d_locked[h], d_level[h], d_errc[h]);
        end
      end
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_locked[h] !== 1'b0 || d_level[h] !== LW'(0)) begin
        tests_failed++;
        $display("FAIL gating_reset[%0d]: locked=%b level=%0d want 0 0", h, d_locked[h], d_level[h]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h80, 0);
    step(1, 8'h00, 0);
    step(1, 8'h80, 0);
    for (int h = 0; h < 2; h++) begin
      tests_run++;
      if (d_locked[h] !== 1'b1 || d_level[h] !== LW'(1) || d_vld[h] !== 1'b1) begin
        tests_failed++;
        $display("FAIL gating_resume[%0d]: locked=%b level=%0d vld=%b want 1 1 1", h, d_locked[h], d_level[h], d_vld[h]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  led;
    logic [31:0] got, exp;
    int          r;
    do_reset();
    repeat (3000) begin
      r = int'($urandom_range(0, 9));
      if (m_locked[0] == 0)  led = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      else if (r < 7)        led = 8'(therm((m_k[0] == 8) ? 0 : m_k[0] + 1));
      else if (r < 8)        led = 8'(therm(m_k[0]));
      else                   led = 8'($urandom);
      step(($urandom_range(0, 3) != 0), led, ($urandom_range(0, 49) == 0));
      for (int h = 0; h < 2; h++) begin
        got = {d_locked[h], d_level[h], d_vld[h], d_done[h], d_err[h], d_errc[h], d_cyc[h]};
        exp = {1'(m_locked[h]), LW'(m_level[h]), 1'(m_vld[h]), 1'(m_done[h]), 1'(m_err[h]),
               8'(m_errc[h]), 16'(m_cyc[h])};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL random[%0d] led=%h: got %h want %h", h, led, got, exp);
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_full_cycle();
    test_corruption();
    test_hold();
    test_saturation();
    test_gating();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
